// File: rtl/clock_set_controller.sv
// ============================================================================
// Module   : clock_set_controller
// Purpose  : RUN / SET_HR / SET_MIN sequencer for the binary clock time-set
//            path; optional hold-to-repeat under CLOCK_SET_AUTO_REPEAT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module clock_set_controller #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int TIMEOUT_S    = 10,
    parameter int FLASH_DIV    = 25_000_000,
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       tick_1Hz,
    output logic       inc_min,
    output logic       inc_hr,
    output logic       sec_clear,
    output logic       run_en,
    output logic [1:0] mode,
    output logic       blank_hr,
    output logic       blank_min
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10
    } state_t;

    localparam int              c_FLASH_W   = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [c_FLASH_W-1:0] c_FLASH_TC = c_FLASH_W'(FLASH_DIV - 1);
    localparam logic [5:0]      c_TIMEOUT_TC = 6'(TIMEOUT_S - 1);

    // CLK_HZ only documents the intended clock rate
    logic w_unused_clk_hz;
    assign w_unused_clk_hz = (CLK_HZ > 0);

    logic                 r_mode_prev, r_inc_prev;
    logic                 r_mode_armed, r_inc_armed;
    logic                 r_mode_rise, r_inc_rise;
    state_t               r_state;
    logic [5:0]           r_idle;
    logic [c_FLASH_W-1:0] r_flash_cnt;
    logic                 r_phase;

    state_t               w_state_nxt;
    logic [5:0]           w_idle_nxt;
    logic [c_FLASH_W-1:0] w_flash_nxt;
    logic                 w_phase_nxt;
    logic                 w_set_mode;
    logic                 w_press_pulse;
    logic                 w_rep_pulse;
    logic                 w_inc_pulse;
    logic                 w_state_chg;

    always_comb begin
        w_set_mode    = (r_state != ST_RUN);
        w_press_pulse = w_set_mode & r_inc_rise & ~r_mode_rise;
        w_inc_pulse   = w_press_pulse | w_rep_pulse;
        w_state_nxt   = r_state;
        w_idle_nxt    = r_idle;

        if (r_mode_rise) begin
            case (r_state)
                ST_RUN:    w_state_nxt = ST_SET_HR;
                ST_SET_HR: w_state_nxt = ST_SET_MIN;
                default:   w_state_nxt = ST_RUN;
            endcase
            w_idle_nxt = 6'd0;
        end else if (!w_set_mode) begin
            w_idle_nxt = 6'd0;
        end else if (w_inc_pulse) begin
            w_idle_nxt = 6'd0;
        end else if (tick_1Hz) begin
            // a button/repeat in the same cycle already took the branch above
            if (r_idle == c_TIMEOUT_TC) begin
                w_state_nxt = ST_RUN;
                w_idle_nxt  = 6'd0;
            end else begin
                w_idle_nxt  = r_idle + 6'd1;
            end
        end

        w_state_chg = (w_state_nxt != r_state);

        if (w_state_chg) begin
            w_flash_nxt = '0;
            w_phase_nxt = 1'b0;
        end else if (r_flash_cnt == c_FLASH_TC) begin
            w_flash_nxt = '0;
            w_phase_nxt = ~r_phase;
        end else begin
            w_flash_nxt = r_flash_cnt + c_FLASH_W'(1);
            w_phase_nxt = r_phase;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            r_mode_prev  <= 1'b0;
            r_inc_prev   <= 1'b0;
            r_mode_armed <= 1'b0;
            r_inc_armed  <= 1'b0;
            r_mode_rise  <= 1'b0;
            r_inc_rise   <= 1'b0;
            r_state      <= ST_RUN;
            r_idle       <= 6'd0;
            r_flash_cnt  <= '0;
            r_phase      <= 1'b0;
            mode         <= ST_RUN;
            run_en       <= 1'b1;
            sec_clear    <= 1'b0;
            inc_hr       <= 1'b0;
            inc_min      <= 1'b0;
            blank_hr     <= 1'b0;
            blank_min    <= 1'b0;
        end else begin
            r_mode_prev  <= btn_mode;
            r_inc_prev   <= btn_inc;
            // a level held through reset must be seen low before it can rise
            r_mode_armed <= r_mode_armed | ~btn_mode;
            r_inc_armed  <= r_inc_armed | ~btn_inc;
            r_mode_rise  <= btn_mode & ~r_mode_prev & r_mode_armed;
            r_inc_rise   <= btn_inc & ~r_inc_prev & r_inc_armed;
            r_state      <= w_state_nxt;
            r_idle       <= w_idle_nxt;
            r_flash_cnt  <= w_flash_nxt;
            r_phase      <= w_phase_nxt;
            mode         <= w_state_nxt;
            run_en       <= (w_state_nxt == ST_RUN);
            sec_clear    <= (w_state_nxt != ST_RUN);
            inc_hr       <= w_inc_pulse & (r_state == ST_SET_HR);
            inc_min      <= w_inc_pulse & (r_state == ST_SET_MIN);
            blank_hr     <= w_phase_nxt & (w_state_nxt == ST_SET_HR);
            blank_min    <= w_phase_nxt & (w_state_nxt == ST_SET_MIN);
        end
    end

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam int c_HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_HOLD_W   = (c_HOLD_MAX > 1) ? $clog2(c_HOLD_MAX) : 1;
    localparam logic [c_HOLD_W-1:0] c_DELAY_TC = c_HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [c_HOLD_W-1:0] c_RATE_TC  = c_HOLD_W'(REPEAT_RATE - 1);

    logic [c_HOLD_W-1:0] r_hold;
    logic                r_hold_active;
    logic                r_hold_first;

    assign w_rep_pulse = r_hold_active & r_inc_prev & ~r_mode_rise & ~r_inc_rise &
                         (r_hold == (r_hold_first ? c_DELAY_TC : c_RATE_TC));

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            r_hold        <= '0;
            r_hold_active <= 1'b0;
            r_hold_first  <= 1'b0;
        end else if (w_state_chg || !r_inc_prev) begin
            r_hold        <= '0;
            r_hold_active <= 1'b0;
            r_hold_first  <= 1'b0;
        end else if (w_press_pulse) begin
            r_hold        <= '0;
            r_hold_active <= 1'b1;
            r_hold_first  <= 1'b1;
        end else if (w_rep_pulse) begin
            r_hold        <= '0;
            r_hold_first  <= 1'b0;
        end else if (r_hold_active) begin
            r_hold        <= r_hold + c_HOLD_W'(1);
        end
    end
`else
    assign w_rep_pulse = 1'b0;

    logic w_unused_repeat;
    assign w_unused_repeat = (REPEAT_DELAY > 0) ^ (REPEAT_RATE > 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_clock_set_controller.sv
// ============================================================================
// Module   : tb_clock_set_controller
// Purpose  : Directed + random bench for clock_set_controller against an
//            event-time reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_clock_set_controller;

    localparam int TIMEOUT_S    = 10;
    localparam int FLASH_DIV    = 8;
    localparam int REPEAT_DELAY = 20;
    localparam int REPEAT_RATE  = 5;

    logic       clk_100MHz = 1'b0;
    logic       reset_n    = 1'b0;
    logic       btn_mode   = 1'b0;
    logic       btn_inc    = 1'b0;
    logic       tick_1Hz   = 1'b0;
    logic       inc_min, inc_hr, sec_clear, run_en, blank_hr, blank_min;
    logic [1:0] mode;

    int vectors     = 0;
    int miscompares = 0;
    int n_hr        = 0;
    int n_min       = 0;

    // reference model: state 0=RUN 1=SET_HR 2=SET_MIN, times in edge numbers
    int e       = 0;
    int m_state = 0;
    int m_entry = 0;
    int m_idle  = 0;
    int m_press = -1;
    bit m_prev_mode, m_prev_inc, m_arm_mode, m_arm_inc;
    bit m_pend_mode, m_pend_inc;
    bit m_inc_hr, m_inc_min;

    clock_set_controller #(
        .CLK_HZ      (100_000_000),
        .TIMEOUT_S   (TIMEOUT_S),
        .FLASH_DIV   (FLASH_DIV),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset_n   (reset_n),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .tick_1Hz  (tick_1Hz),
        .inc_min   (inc_min),
        .inc_hr    (inc_hr),
        .sec_clear (sec_clear),
        .run_en    (run_en),
        .mode      (mode),
        .blank_hr  (blank_hr),
        .blank_min (blank_min)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, e);
        end
    endtask

    function automatic bit repeat_due();
        int d;
        if (m_press < 0) return 1'b0;
        d = e - m_press;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
        return (d == REPEAT_DELAY) || (d > REPEAT_DELAY && ((d - REPEAT_DELAY) % REPEAT_RATE) == 0);
`else
        return (d < 0);
`endif
    endfunction

    task automatic model_edge();
        bit rep;
        e++;
        m_inc_hr  = 1'b0;
        m_inc_min = 1'b0;
        if (!reset_n) begin
            m_state = 0; m_entry = e; m_idle = 0; m_press = -1;
            m_prev_mode = 0; m_prev_inc = 0; m_arm_mode = 0; m_arm_inc = 0;
            m_pend_mode = 0; m_pend_inc = 0;
        end else begin
            if (!m_prev_inc) m_press = -1;
            rep = (m_state != 0) && repeat_due();
            if (m_pend_mode) begin
                m_state = (m_state + 1) % 3;
                m_entry = e; m_idle = 0; m_press = -1;
            end else if (m_state != 0 && (m_pend_inc || rep)) begin
                if (m_state == 1) m_inc_hr = 1'b1;
                else              m_inc_min = 1'b1;
                m_idle = 0;
                if (m_pend_inc) m_press = e;
            end else if (m_state != 0 && tick_1Hz) begin
                m_idle++;
                if (m_idle == TIMEOUT_S) begin
                    m_state = 0; m_entry = e; m_press = -1;
                end
            end
            m_pend_mode = btn_mode && !m_prev_mode && m_arm_mode;
            m_pend_inc  = btn_inc && !m_prev_inc && m_arm_inc;
            m_arm_mode  = m_arm_mode | !btn_mode;
            m_arm_inc   = m_arm_inc | !btn_inc;
            m_prev_mode = btn_mode;
            m_prev_inc  = btn_inc;
        end
    endtask

    task automatic step();
        bit phase;
        @(posedge clk_100MHz);
        model_edge();
        @(negedge clk_100MHz);
        phase = (((e - m_entry) / FLASH_DIV) % 2) == 1;
        check("mode",      mode,      m_state);
        check("run_en",    run_en,    m_state == 0);
        check("sec_clear", sec_clear, m_state != 0);
        check("inc_hr",    inc_hr,    m_inc_hr);
        check("inc_min",   inc_min,   m_inc_min);
        check("blank_hr",  blank_hr,  (m_state == 1) && phase);
        check("blank_min", blank_min, (m_state == 2) && phase);
        if (inc_hr === 1'b1)  n_hr++;
        if (inc_min === 1'b1) n_min++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press_mode();
        btn_mode = 1'b1; steps(2);
        btn_mode = 1'b0; steps(2);
    endtask

    task automatic press_inc();
        btn_inc = 1'b1; steps(2);
        btn_inc = 1'b0; steps(2);
    endtask

    task automatic strobe();
        tick_1Hz = 1'b1; step();
        tick_1Hz = 1'b0; steps(3);
    endtask

    initial begin
        int flip_m, flip_i;
        steps(2);
        reset_n = 1'b1;
        steps(3);

        // mode sequence 01, 10, 00
        press_mode(); check("seq_hr",  mode, 2'b01);
        press_mode(); check("seq_min", mode, 2'b10);
        press_mode(); check("seq_run", mode, 2'b00);

        // five presses in SET_HR, then five in RUN
        press_mode();
        n_hr = 0; n_min = 0;
        for (int i = 0; i < 5; i++) press_inc();
        check("hr_pulses", n_hr, 5);
        check("hr_min_quiet", n_min, 0);
        press_mode(); press_mode();
        n_hr = 0; n_min = 0;
        for (int i = 0; i < 5; i++) press_inc();
        check("run_no_pulses", n_hr + n_min, 0);

        // simultaneous rise in SET_HR: mode wins
        press_mode();
        n_hr = 0;
        btn_mode = 1'b1; btn_inc = 1'b1; steps(2);
        btn_mode = 1'b0; btn_inc = 1'b0; steps(2);
        check("simul_mode", mode, 2'b10);
        check("simul_no_inc", n_hr, 0);
        press_mode();

        // idle timeout after TIMEOUT_S strobes
        press_mode();
        for (int i = 1; i <= TIMEOUT_S; i++) begin
            strobe();
            if (i == TIMEOUT_S - 1) check("to_before", mode, 2'b01);
        end
        check("to_exit", mode, 2'b00);

        // press at strobe 9 restarts the idle window
        press_mode();
        for (int i = 0; i < TIMEOUT_S - 1; i++) strobe();
        press_inc();
        for (int i = 1; i <= TIMEOUT_S; i++) begin
            strobe();
            if (i == TIMEOUT_S - 1) check("to_restart_hold", mode, 2'b01);
        end
        check("to_restart_exit", mode, 2'b00);

        // hold btn_inc 40 cycles in SET_MIN
        press_mode(); press_mode();
        n_min = 0;
        btn_inc = 1'b1; steps(40);
        btn_inc = 1'b0; steps(4);
`ifdef CLOCK_SET_AUTO_REPEAT_EN
        check("hold_pulses", n_min, 5);
`else
        check("hold_pulses", n_min, 1);
`endif
        press_mode();

        // reset in SET_MIN with btn_inc held
        press_mode(); press_mode();
        btn_inc = 1'b1; steps(3);
        reset_n = 1'b0; step();
        check("rst_mode", mode, 2'b00);
        check("rst_run_en", run_en, 1'b1);
        reset_n = 1'b1;
        n_hr = 0; n_min = 0;
        steps(6);
        check("rst_held_no_pulse", n_hr + n_min, 0);
        btn_inc = 1'b0; steps(2);

        // randomised traffic in phases of differing button activity
        for (int ph = 0; ph < 16; ph++) begin
            flip_m = $urandom_range(8, 40);
            flip_i = (ph % 3 == 0) ? 60 : $urandom_range(2, 8);
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, flip_m - 1) == 0) btn_mode = ~btn_mode;
                if ($urandom_range(0, flip_i - 1) == 0) btn_inc  = ~btn_inc;
                tick_1Hz = ($urandom_range(0, 5) == 0);
                reset_n  = ($urandom_range(0, 499) != 0);
                step();
            end
        end
        reset_n = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; tick_1Hz = 1'b0;
        steps(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
